// File: rtl/joy_db9_scan.sv
// Multi-port DB9 joystick scanner: drives the shared select line and decodes SMS / MD 3-button / MD 6-button pads.
// Define JOY_SIXBTN_EN to enable the 8-phase scan with 6-button detection (default: 4-phase scan, bits [11:8] and six_o are 0).
module joy_db9_port (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_s2,
  input  logic        i_s3,
  input  logic        i_s5,
  input  logic        i_s6,
  input  logic        i_commit,
  input  logic [5:0]  i_pin,
  output logic [11:0] o_joy,
  output logic        o_six
);
  logic [11:0] r_sh;
  logic        r_six_tmp;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sh      <= '0;
      r_six_tmp <= 1'b0;
      o_joy     <= '0;
      o_six     <= 1'b0;
    end else begin
      if (i_s2) begin
        r_sh[5:0] <= ~i_pin;
        r_six_tmp <= 1'b0;
      end
      // R and L both low while select is low identifies a Mega Drive pad
      if (i_s3) begin
        if (!i_pin[3] && !i_pin[2]) r_sh[7:6] <= ~i_pin[5:4];
        else                        r_sh[7:4] <= {2'b00, ~i_pin[5:4]};
      end
      if (i_s5 && (i_pin[3:0] == 4'b0000)) r_six_tmp <= 1'b1;
      if (i_s6) r_sh[11:8] <= r_six_tmp ? ~i_pin[3:0] : 4'h0;
      if (i_commit) begin
        o_joy <= r_sh;
        o_six <= r_six_tmp;
      end
    end
  end
endmodule

module joy_db9_scan #(
  parameter int NUM_PORTS  = 2,
  parameter int TICK_DIV   = 1536,
  parameter int IDLE_TICKS = 248
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [6*NUM_PORTS-1:0]  joy_i,
  output logic                    p7_o,
  output logic [12*NUM_PORTS-1:0] joy_o,
  output logic [NUM_PORTS-1:0]    six_o,
  output logic                    frame_o
);
`ifdef JOY_SIXBTN_EN
  localparam int NACT = 8;
`else
  localparam int NACT = 4;
`endif
  localparam int NPH = NACT + IDLE_TICKS;
  localparam int PW  = $clog2(NPH);
  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]               r_cnt;
  logic                        w_tick;
  logic [PW-1:0]               r_ph, w_ph_nxt;
  logic [NUM_PORTS-1:0][5:0]   r_sync1, r_sync2;
  logic                        w_p7_nxt, w_s2, w_s3, w_s5, w_s6, w_commit;

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sync1 <= '1;
      r_sync2 <= '1;
      p7_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_sync1 <= joy_i;
      r_sync2 <= r_sync1;
      p7_o    <= w_p7_nxt;
      frame_o <= w_commit;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_ph <= '0;
    else       r_ph <= w_ph_nxt;
  end

  always_comb begin
    w_ph_nxt = r_ph;
    if (w_tick) w_ph_nxt = (r_ph == PW'(NPH - 1)) ? '0 : r_ph + 1'b1;
  end

  // Select level and sample strobes for the tick ending the current phase
  always_comb begin
    w_p7_nxt = p7_o;
    w_s2     = 1'b0;
    w_s3     = 1'b0;
    w_s5     = 1'b0;
    w_s6     = 1'b0;
    w_commit = 1'b0;
    if (w_tick) begin
      w_p7_nxt = 1'b1;
      case (r_ph)
        PW'(0): w_p7_nxt = 1'b0;
        PW'(2): begin w_s2 = 1'b1; w_p7_nxt = 1'b0; end
        PW'(3): w_s3 = 1'b1;
`ifdef JOY_SIXBTN_EN
        PW'(4): w_p7_nxt = 1'b0;
        PW'(5): w_s5 = 1'b1;
        PW'(6): begin w_s6 = 1'b1; w_p7_nxt = 1'b0; end
`endif
        default: ;
      endcase
      w_commit = (r_ph == PW'(NACT));
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    joy_db9_port u_port (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .i_s2     (w_s2),
      .i_s3     (w_s3),
      .i_s5     (w_s5),
      .i_s6     (w_s6),
      .i_commit (w_commit),
      .i_pin    (r_sync2[p]),
      .o_joy    (joy_o[12*p +: 12]),
      .o_six    (six_o[p])
    );
  end
endmodule
